// File: rtl/linescanner_sensor_emulator.sv
// Linescanner sensor emulator: answers the capture side's rst_cvc/rst_cds/sample/load_pulse
// with end_adc, lval and a deterministic 8-bit pixel pattern; exposure and readout run independently.
// Optional macro LINESCANNER_EMU_EXPOSURE_GAIN_EN: pixel value tracks exposure length (saturating).
module linescanner_sensor_emulator #(
  parameter int PIXELS_PER_LINE = 1024,
  parameter int ADC_CYCLES      = 16,
  parameter int PIX_CNT_W       = 16
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       rst_cvc,
  input  logic       rst_cds,
  input  logic       sample,
  input  logic       load_pulse,
  input  logic       clear_status,
  output logic       end_adc,
  output logic       lval,
  output logic [7:0] data,
  output logic [2:0] status
);

  localparam int ADC_W = (ADC_CYCLES > 1) ? $clog2(ADC_CYCLES) : 1;
  localparam logic [ADC_W-1:0]     ADC_LAST = ADC_W'(ADC_CYCLES - 1);
  localparam logic [PIX_CNT_W-1:0] PIX_LAST = PIX_CNT_W'(PIXELS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXPOSE  = 2'd1,
    ST_CONVERT = 2'd2
  } state_t;

  state_t               state_q;
  logic                 end_adc_q;
  logic [ADC_W-1:0]     adc_cnt_q;
  logic [7:0]           line_tag_q;
  logic                 sample_q;
  logic                 line_ready_q, line_ready_d;
  logic [2:0]           status_q, status_d, status_set;

  logic                 lval_q, lval_d;
  logic [PIX_CNT_W-1:0] pix_q, pix_d;
  logic [7:0]           rd_tag_q, rd_tag_d;
  logic [PIX_CNT_W-1:0] line_index_q, line_index_d;
  logic [7:0]           data_q, data_d;

`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
  logic [7:0]           exp_cnt_q;
  logic [7:0]           exp_line_q;
  logic [7:0]           rd_exp_q, rd_exp_d;
  logic [8:0]           gain_sum;
`endif

  logic sample_rise, start_ok, start_err, expose_abort, conv_done;
  logic load_accept, load_err, load_busy, overrun_conv, last_pix;

  // Event decode shared by the exposure FSM, the readout engine and the status flags.
  always_comb begin
    sample_rise  = sample & ~sample_q;
    start_ok     = (state_q == ST_IDLE) & enable & sample_rise & ~rst_cvc & ~rst_cds;
    start_err    = (state_q == ST_IDLE) & enable & sample_rise & (rst_cvc | rst_cds);
    expose_abort = (state_q == ST_EXPOSE) & rst_cvc;
    conv_done    = (state_q == ST_CONVERT) & (adc_cnt_q == ADC_LAST);
    load_accept  = load_pulse & ~lval_q & line_ready_q;
    load_err     = load_pulse & ~lval_q & ~line_ready_q;
    load_busy    = load_pulse & lval_q;
    // A load accepted on the conversion edge drains the old line, so the new one is no overrun.
    overrun_conv = conv_done & line_ready_q & ~load_accept;
    last_pix     = lval_q & (pix_q == PIX_LAST);
    status_set   = {overrun_conv | load_busy, load_err, start_err | expose_abort};
    // Set beats clear so a flag raised on the clear cycle is not lost.
    status_d     = (clear_status ? 3'b000 : status_q) | status_set;
    line_ready_d = line_ready_q;
    if (conv_done) begin
      line_ready_d = 1'b1;
    end else if (load_accept) begin
      line_ready_d = 1'b0;
    end
  end

  // Registered sample for edge detection, line_ready handshake and sticky status.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      sample_q     <= 1'b0;
      line_ready_q <= 1'b0;
      status_q     <= 3'b000;
    end else begin
      sample_q     <= sample;
      line_ready_q <= line_ready_d;
      status_q     <= status_d;
    end
  end

  // Exposure/convert FSM with registered end_adc.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      end_adc_q  <= 1'b1;
      adc_cnt_q  <= '0;
      line_tag_q <= '0;
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
      exp_cnt_q  <= '0;
      exp_line_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q   <= ST_EXPOSE;
            end_adc_q <= 1'b0;
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
            exp_cnt_q <= 8'd1;
`endif
          end
        end
        ST_EXPOSE: begin
          if (rst_cvc) begin
            state_q   <= ST_IDLE;
            end_adc_q <= 1'b1;
          end else if (!sample) begin
            state_q   <= ST_CONVERT;
            adc_cnt_q <= '0;
          end else begin
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
            if (exp_cnt_q != 8'hFF) begin
              exp_cnt_q <= exp_cnt_q + 8'd1;
            end
`endif
          end
        end
        ST_CONVERT: begin
          if (conv_done) begin
            state_q    <= ST_IDLE;
            end_adc_q  <= 1'b1;
            line_tag_q <= line_index_q[7:0];
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
            exp_line_q <= exp_cnt_q;
`endif
          end else begin
            adc_cnt_q <= adc_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          end_adc_q <= 1'b1;
        end
      endcase
    end
  end

  // Readout next-state: a load snapshots the converted line so a new conversion can land meanwhile.
  always_comb begin
    lval_d       = lval_q;
    pix_d        = pix_q;
    rd_tag_d     = rd_tag_q;
    line_index_d = line_index_q;
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
    rd_exp_d     = rd_exp_q;
`endif
    if (load_accept) begin
      lval_d   = 1'b1;
      pix_d    = '0;
      rd_tag_d = line_tag_q;
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
      rd_exp_d = exp_line_q;
`endif
    end else if (lval_q) begin
      if (last_pix) begin
        lval_d       = 1'b0;
        pix_d        = '0;
        line_index_d = line_index_q + 1'b1;
      end else begin
        pix_d = pix_q + 1'b1;
      end
    end
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
    gain_sum = {1'b0, pix_d[7:0]} + {1'b0, rd_exp_d};
    data_d   = lval_d ? (gain_sum[8] ? 8'hFF : gain_sum[7:0]) : 8'h00;
`else
    data_d   = lval_d ? (pix_d[7:0] + rd_tag_d) : 8'h00;
`endif
  end

  // Readout registers; data is registered in step with lval.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      lval_q       <= 1'b0;
      pix_q        <= '0;
      rd_tag_q     <= '0;
      line_index_q <= '0;
      data_q       <= 8'h00;
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
      rd_exp_q     <= '0;
`endif
    end else begin
      lval_q       <= lval_d;
      pix_q        <= pix_d;
      rd_tag_q     <= rd_tag_d;
      line_index_q <= line_index_d;
      data_q       <= data_d;
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
      rd_exp_q     <= rd_exp_d;
`endif
    end
  end

  assign end_adc = end_adc_q;
  assign lval    = lval_q;
  assign data    = data_q;
  assign status  = status_q;

endmodule

// File: tb/tb_linescanner_sensor_emulator.sv
// Directed bench for linescanner_sensor_emulator with PIXELS_PER_LINE=8, ADC_CYCLES=4.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_linescanner_sensor_emulator;

  localparam int PPL = 8;
  localparam int ADC = 4;

  logic       pixel_clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       rst_cvc = 1'b0;
  logic       rst_cds = 1'b0;
  logic       sample = 1'b0;
  logic       load_pulse = 1'b0;
  logic       clear_status = 1'b0;
  logic       end_adc;
  logic       lval;
  logic [7:0] data;
  logic [2:0] status;

  int checks = 0;
  int failures = 0;

  linescanner_sensor_emulator #(
    .PIXELS_PER_LINE(PPL),
    .ADC_CYCLES(ADC),
    .PIX_CNT_W(16)
  ) dut (
    .pixel_clock(pixel_clock),
    .reset(reset),
    .enable(enable),
    .rst_cvc(rst_cvc),
    .rst_cds(rst_cds),
    .sample(sample),
    .load_pulse(load_pulse),
    .clear_status(clear_status),
    .end_adc(end_adc),
    .lval(lval),
    .data(data),
    .status(status)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge pixel_clock);
      #1;
    end
  endtask

  // Expected pixel value for pixel i of a line with the given tag and sample-high length.
  function automatic int exp_pix(input int i, input int tag, input int explen);
`ifdef LINESCANNER_EMU_EXPOSURE_GAIN_EN
    int e;
    e = (explen > 255) ? 255 : explen;
    return ((i + e) > 255) ? 255 : (i + e);
`else
    return (i + tag) % 256;
`endif
  endfunction

  // Sample high for n edges, then low until the conversion completes.
  task automatic expose(input int n);
    sample = 1'b1;
    tick(n);
    sample = 1'b0;
    tick(1 + ADC);
  endtask

  // One full burst; a second load_pulse is injected after pixel inject (if inject >= 0).
  task automatic readout(input int tag, input int explen, input int inject);
    load_pulse = 1'b1;
    tick(1);
    load_pulse = 1'b0;
    for (int i = 0; i < PPL; i++) begin
      chk("burst_lval", 32'(lval), 1);
      chk("burst_data", 32'(data), exp_pix(i, tag, explen));
      if (i == inject) load_pulse = 1'b1;
      tick(1);
      load_pulse = 1'b0;
    end
    chk("burst_end_lval", 32'(lval), 0);
    chk("burst_end_data", 32'(data), 0);
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_end_adc", 32'(end_adc), 1);
    chk("rst_lval", 32'(lval), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_status", 32'(status), 0);
    reset = 1'b0;
    enable = 1'b1;
    tick(2);

    // Line 0: 50-cycle exposure with detailed end_adc timing
    sample = 1'b1;
    tick(1);
    chk("expose_end_adc_low", 32'(end_adc), 0);
    tick(49);
    sample = 1'b0;
    tick(1);
    chk("convert_end_adc_low", 32'(end_adc), 0);
    tick(ADC - 1);
    chk("convert_last_low", 32'(end_adc), 0);
    tick(1);
    chk("convert_done_high", 32'(end_adc), 1);
    readout(0, 50, -1);

    // Line 1: line_index advanced
    expose(5);
    readout(1, 5, -1);

    // Protocol error: rst_cds high on the sample rise
    rst_cds = 1'b1;
    sample = 1'b1;
    tick(1);
    chk("proterr_end_adc", 32'(end_adc), 1);
    chk("proterr_status", 32'(status), 1);
    sample = 1'b0;
    rst_cds = 1'b0;
    tick(1);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    chk("clear_status", 32'(status), 0);

    // enable=0 ignores sample and sets nothing
    enable = 1'b0;
    sample = 1'b1;
    tick(2);
    chk("disabled_end_adc", 32'(end_adc), 1);
    chk("disabled_status", 32'(status), 0);
    sample = 1'b0;
    enable = 1'b1;
    tick(1);

    // Load with no converted line
    load_pulse = 1'b1;
    tick(1);
    load_pulse = 1'b0;
    chk("loaderr_status", 32'(status), 2);
    chk("loaderr_lval", 32'(lval), 0);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;

    // Line 2: load during lval flags overrun, burst length unchanged
    expose(7);
    readout(2, 7, 3);
    chk("busy_load_status", 32'(status), 4);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;

    // Two exposures without a load: overrun, second line wins
    expose(20);
    chk("single_line_status", 32'(status), 0);
    expose(30);
    chk("overrun_status", 32'(status), 4);
    readout(3, 30, -1);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;

    // Load accepted on the same edge a conversion completes
    expose(12);
    sample = 1'b1;
    tick(15);
    sample = 1'b0;
    tick(ADC);
    load_pulse = 1'b1;
    tick(1);
    load_pulse = 1'b0;
    chk("same_edge_status", 32'(status), 0);
    chk("same_edge_lval", 32'(lval), 1);
    chk("same_edge_end_adc", 32'(end_adc), 1);
    chk("same_edge_data0", 32'(data), exp_pix(0, 4, 12));
    for (int i = 1; i < PPL; i++) begin
      tick(1);
      chk("same_edge_data", 32'(data), exp_pix(i, 4, 12));
    end
    tick(1);
    chk("same_edge_end", 32'(lval), 0);
    readout(4, 15, -1);
    chk("same_edge_no_overrun", 32'(status), 0);

    // Exposure-length patterns (gain build: 10..17 and saturated 255)
    expose(10);
    readout(6, 10, -1);
    expose(300);
    readout(7, 300, -1);

    // Reset on the 3rd lval cycle while a new exposure runs
    expose(6);
    load_pulse = 1'b1;
    sample = 1'b1;
    tick(1);
    load_pulse = 1'b0;
    tick(2);
    chk("pre_reset_lval", 32'(lval), 1);
    chk("pre_reset_end_adc", 32'(end_adc), 0);
    reset = 1'b1;
    #1;
    chk("async_rst_lval", 32'(lval), 0);
    chk("async_rst_data", 32'(data), 0);
    chk("async_rst_end_adc", 32'(end_adc), 1);
    sample = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("post_reset_status", 32'(status), 0);
    expose(9);
    readout(0, 9, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
